// File: rtl/simd_alu_pkg.sv
// -----------------------------------------------------------------------------
// simd_alu_pkg
// Shared definitions for the SIMD adder datapath and its request scheduler:
// default widths, lane-mode encodings, byte-lane sign-bit position, the
// request packet layout and a lane-boundary helper.
// -----------------------------------------------------------------------------
package simd_alu_pkg;

  localparam int SIMD_DATA_WIDTH            = 256;
  localparam int SIMD_ADDER_DATA_MODE_WIDTH = 2;

  // Lane-mode encodings (lane width = 8 << mode bits)
  localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_8B  = 2'd0;
  localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_16B = 2'd1;
  localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_32B = 2'd2;
  localparam logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] MODE_64B = 2'd3;

  // Sign bit position inside a byte lane
  localparam int MSB_8B = 7;

  // Widest requester ID carried in a packet (up to 8 requesters)
  localparam int SIMD_MAX_ID_W = 3;

  typedef struct packed {
    logic [SIMD_DATA_WIDTH-1:0]            a;
    logic [SIMD_DATA_WIDTH-1:0]            b;
    logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] mode;
    logic                                  is_signed;
    logic [SIMD_MAX_ID_W-1:0]              id;
  } simd_add_req_t;

  // True when byte index byte_idx is the least significant byte of a lane,
  // i.e. where the carry chain must be broken for the given mode.
  function automatic logic lane_start(
    input logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] mode,
    input int                                    byte_idx
  );
    int span;
    span = 1 << mode;
    return (byte_idx % span) == 0;
  endfunction

endpackage

// File: rtl/simd_alu_adder_top.sv
// -----------------------------------------------------------------------------
// simd_alu_adder_top
// Purely combinational lane-wise adder. A byte-granular carry chain is cut at
// every lane boundary selected by mode, so lane sums wrap modulo 2^lane_width.
// Ports:
//   a, b       : operand vectors
//   mode       : lane width select (0=8b .. 3=64b)
//   is_signed  : selects signed (vs. unsigned carry) overflow for 8b lanes
//   result     : lane-wise sum
//   ovf        : per-byte overflow, only populated in 8b mode
// -----------------------------------------------------------------------------
module simd_alu_adder_top
  import simd_alu_pkg::*;
#(
  parameter int DW = simd_alu_pkg::SIMD_DATA_WIDTH,
  parameter int MW = simd_alu_pkg::SIMD_ADDER_DATA_MODE_WIDTH
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [MW-1:0]   mode,
  input  logic            is_signed,
  output logic [DW-1:0]   result,
  output logic [DW/8-1:0] ovf
);

  localparam int NB = DW / 8;

  logic [NB-1:0] byte_cout;

  // Carry chain evaluated in one process so the ripple is a plain variable,
  // not a self-referencing vector.
  always_comb begin : p_chain
    logic       carry;
    logic       cin;
    logic [8:0] s;
    result    = '0;
    byte_cout = '0;
    carry     = 1'b0;
    cin       = 1'b0;
    s         = '0;
    for (int j = 0; j < NB; j++) begin
      cin = lane_start(mode, j) ? 1'b0 : carry;
      s   = {1'b0, a[j*8 +: 8]} + {1'b0, b[j*8 +: 8]} + {8'd0, cin};
      result[j*8 +: 8] = s[7:0];
      byte_cout[j]     = s[8];
      carry            = s[8];
    end
  end

  // Overflow only has meaning when every byte is its own lane.
  for (genvar gi = 0; gi < NB; gi++) begin : g_ovf
    logic sa, sb, ss;
    assign sa = a[gi*8 + MSB_8B];
    assign sb = b[gi*8 + MSB_8B];
    assign ss = result[gi*8 + MSB_8B];
    assign ovf[gi] = (mode == MODE_8B) &
                     (is_signed ? ((sa == sb) & (ss != sa)) : byte_cout[gi]);
  end

endmodule

// File: rtl/simd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// simd_rr_arbiter
// Round-robin grant over NUM_REQ requesters. The search starts at the pointer
// and wraps; the pointer moves to one past the winner when accept is strobed.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : per-requester request
//   accept        : the current grant was taken this cycle
//   grant_onehot  : one-hot grant (all zero when nobody requests)
//   grant_idx     : encoded grant index
// -----------------------------------------------------------------------------
module simd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] rr_ptr_next;

  always_comb begin : p_grant
    int   idx;
    logic found;
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = ID_W'(idx);
      end
    end
  end

  // Explicit wrap keeps non-power-of-two requester counts correct.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_reg <= '0;
    else     rr_ptr_reg <= rr_ptr_next;
  end

endmodule

// File: rtl/simd_alu_add_sched.sv
// -----------------------------------------------------------------------------
// simd_alu_add_sched
// Shares one simd_alu_adder_top between NUM_REQ requesters. A round-robin
// arbiter picks one packet per cycle into an issue register (stage 1) that
// feeds the adder; the adder output is captured in an output register
// (stage 2) that drives the back-pressurable response channel.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid / req_ready    : per-requester handshake (ready is one-hot or 0)
//   req_a, req_b             : operands, requester i in slice i
//   req_mode, req_signed     : lane mode / signedness per requester
//   rsp_valid / rsp_ready    : response handshake
//   rsp_id                   : originating requester
//   rsp_result, rsp_ovf      : lane-wise sum and per-byte overflow
// -----------------------------------------------------------------------------
module simd_alu_add_sched #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2,
  parameter int NUM_REQ                    = 4,
  parameter int ID_W                       = $clog2(NUM_REQ)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*SIMD_DATA_WIDTH-1:0]      req_a,
  input  logic [NUM_REQ*SIMD_DATA_WIDTH-1:0]      req_b,
  input  logic [NUM_REQ*SIMD_ADDER_DATA_MODE_WIDTH-1:0] req_mode,
  input  logic [NUM_REQ-1:0]                      req_signed,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [ID_W-1:0]                         rsp_id,
  output logic [SIMD_DATA_WIDTH-1:0]              rsp_result,
  output logic [SIMD_DATA_WIDTH/8-1:0]            rsp_ovf
);

  localparam int DW = SIMD_DATA_WIDTH;
  localparam int MW = SIMD_ADDER_DATA_MODE_WIDTH;
  localparam int OW = DW / 8;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               xfer;
  logic               s1_load_en;
  logic               s2_load_en;

  logic               s1_valid_reg;
  logic [DW-1:0]      s1_a_reg;
  logic [DW-1:0]      s1_b_reg;
  logic [MW-1:0]      s1_mode_reg;
  logic               s1_signed_reg;
  logic [ID_W-1:0]    s1_id_reg;

  logic               s2_valid_reg;
  logic [DW-1:0]      s2_result_reg;
  logic [OW-1:0]      s2_ovf_reg;
  logic [ID_W-1:0]    s2_id_reg;

  logic [DW-1:0]      add_result;
  logic [OW-1:0]      add_ovf;

  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;
  logic [MW-1:0]      sel_mode;
  logic               sel_signed;

  simd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .accept       (xfer),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  // The stall chain only reaches req_ready, never the grant itself.
  assign s2_load_en = s1_valid_reg & (~s2_valid_reg | rsp_ready);
  assign s1_load_en = ~s1_valid_reg | s2_load_en;
  assign req_ready  = grant_onehot & {NUM_REQ{s1_load_en}};
  assign xfer       = |(req_valid & req_ready);

  assign sel_a      = req_a[int'(grant_idx)*DW +: DW];
  assign sel_b      = req_b[int'(grant_idx)*DW +: DW];
  assign sel_mode   = req_mode[int'(grant_idx)*MW +: MW];
  assign sel_signed = req_signed[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_mode_reg   <= '0;
      s1_signed_reg <= 1'b0;
      s1_id_reg     <= '0;
    end else if (s1_load_en) begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        s1_a_reg      <= sel_a;
        s1_b_reg      <= sel_b;
        s1_mode_reg   <= sel_mode;
        s1_signed_reg <= sel_signed;
        s1_id_reg     <= grant_idx;
      end
    end
  end

  simd_alu_adder_top #(
    .DW (DW),
    .MW (MW)
  ) u_adder (
    .a         (s1_a_reg),
    .b         (s1_b_reg),
    .mode      (s1_mode_reg),
    .is_signed (s1_signed_reg),
    .result    (add_result),
    .ovf       (add_ovf)
  );

  // Data fields only change on a load, so a stalled response is bit-stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_ovf_reg    <= '0;
      s2_id_reg     <= '0;
    end else if (s2_load_en) begin
      s2_valid_reg  <= 1'b1;
      s2_result_reg <= add_result;
      s2_ovf_reg    <= add_ovf;
      s2_id_reg     <= s1_id_reg;
    end else if (rsp_ready) begin
      s2_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid  = s2_valid_reg;
  assign rsp_id     = s2_id_reg;
  assign rsp_result = s2_result_reg;
  assign rsp_ovf    = s2_ovf_reg;

endmodule

// File: tb/tb_simd_alu_add_sched.sv
module tb_simd_alu_add_sched;

  localparam int W  = 256;
  localparam int MW = 2;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int OW = W / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N*MW-1:0] req_mode = '0;
  logic [N-1:0]    req_signed = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_result;
  logic [OW-1:0]   rsp_ovf;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] wide_sum;

  simd_alu_add_sched #(
    .SIMD_DATA_WIDTH            (W),
    .SIMD_ADDER_DATA_MODE_WIDTH (MW),
    .NUM_REQ                    (N),
    .ID_W                       (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_mode   (req_mode),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [MW-1:0] m, input logic s);
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
    req_mode[i*MW +: MW] = m;
    req_signed[i]       = s;
  endtask

  task automatic chk_rsp(input string tag, input int id, input logic [W-1:0] res);
    chk({tag, "_valid"}, W'(rsp_valid), W'(1));
    chk({tag, "_id"}, W'(rsp_id), W'(id));
    chk({tag, "_result"}, rsp_result, res);
  endtask

  initial begin
    wide_sum = {4{64'hFFFF_FFFF_FFFF_FFFE}};

    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_req_ready", W'(req_ready), W'(0));
    chk("rst_rsp_id", W'(rsp_id), W'(0));
    chk("rst_rsp_result", rsp_result, W'(0));
    chk("rst_rsp_ovf", W'(rsp_ovf), W'(0));
    chk("rst_rr_ptr", W'(dut.u_arb.rr_ptr_reg), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // ---------------- round-robin fairness ----------------
    for (int i = 0; i < N; i++) set_req(i, W'(i + 1), W'(8'h10), 2'd0, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'hF;
      if (k == 8) req_valid = 4'h0;
      #1;
      if (k < 8) chk("rr_ready", W'(req_ready), W'(1 << (k % 4)));
      if (k >= 2) chk_rsp("rr_rsp", (k - 2) % 4, W'(32'h11 + ((k - 2) % 4)));
      $display("rr cycle %0d: req_ready=%b rsp_valid=%0d rsp_id=%0d", k, req_ready, rsp_valid, rsp_id);
    end
    @(negedge clk); #1;
    chk("rr_drained", W'(rsp_valid), W'(0));
    chk("rr_ptr_after_rr", W'(dut.u_arb.rr_ptr_reg), W'(0));

    // ---------------- single signed add ----------------
    set_req(0, W'(8'h7F), W'(8'h01), 2'd0, 1'b1);
    req_valid = 4'b0001;
    #1 chk("sa_ready", W'(req_ready), W'(4'b0001));
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk("sa_lat1", W'(rsp_valid), W'(0));
    @(negedge clk); #1;
    chk_rsp("sa_rsp", 0, W'(8'h80));
    chk("sa_ovf", W'(rsp_ovf), W'(1));
    $display("signed add: result=%0h ovf=%0h id=%0d", rsp_result, rsp_ovf, rsp_id);
    @(negedge clk); #1;
    chk("sa_done", W'(rsp_valid), W'(0));

    // ---------------- pointer wrap (pointer at 1) ----------------
    set_req(3, W'(1), W'(2), 2'd0, 1'b0);
    set_req(0, W'(3), W'(4), 2'd0, 1'b0);
    req_valid = 4'b1000;
    #1 chk("wrap_ready3", W'(req_ready), W'(4'b1000));
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("wrap_ready0", W'(req_ready), W'(4'b0001));
    chk("wrap_ptr0", W'(dut.u_arb.rr_ptr_reg), W'(0));
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk_rsp("wrap_rsp3", 3, W'(3));
    chk("wrap_ptr1", W'(dut.u_arb.rr_ptr_reg), W'(1));
    @(negedge clk); #1;
    chk_rsp("wrap_rsp0", 0, W'(7));
    $display("wrap: second response id=%0d result=%0h", rsp_id, rsp_result);
    @(negedge clk); #1;
    chk("wrap_done", W'(rsp_valid), W'(0));

    // ---------------- back-pressure (pointer at 1: grants 1,2 then 0) ----------------
    for (int i = 0; i < 3; i++) set_req(i, W'(32'h20 + i), W'(1), 2'd0, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    #1 chk("bp_ready1", W'(req_ready), W'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0101;
    #1 chk("bp_ready2", W'(req_ready), W'(4'b0100));
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("bp_full_ready", W'(req_ready), W'(0));
    chk_rsp("bp_head", 1, W'(8'h22));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_stall_ready", W'(req_ready), W'(0));
      chk_rsp("bp_stall", 1, W'(8'h22));
      $display("stall cycle %0d: rsp_id=%0d result=%0h", k, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", W'(req_ready), W'(4'b0001));
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk_rsp("bp_rsp2", 2, W'(8'h23));
    @(negedge clk); #1;
    chk_rsp("bp_rsp0", 0, W'(8'h21));
    @(negedge clk); #1;
    chk("bp_done", W'(rsp_valid), W'(0));

    // ---------------- wide lanes (pointer at 1) ----------------
    set_req(1, {W{1'b1}}, {W{1'b1}}, 2'd3, 1'b0);
    req_valid = 4'b0010;
    #1 chk("wide_ready", W'(req_ready), W'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk); #1;
    chk_rsp("wide_rsp", 1, wide_sum);
    chk("wide_ovf", W'(rsp_ovf), W'(0));
    $display("wide: result=%0h ovf=%0h", rsp_result, rsp_ovf);
    @(negedge clk);

    // ---------------- reset mid-flight (pointer at 2) ----------------
    set_req(2, W'(5), W'(6), 2'd0, 1'b0);
    set_req(3, W'(7), W'(8), 2'd0, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    #1 chk("mf_ready2", W'(req_ready), W'(4'b0100));
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("mf_ready3", W'(req_ready), W'(4'b1000));
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk("mf_inflight", W'(rsp_valid), W'(1));
    #1 rst = 1'b1;
    #1;
    chk("mf_rst_valid", W'(rsp_valid), W'(0));
    chk("mf_rst_id", W'(rsp_id), W'(0));
    chk("mf_rst_ptr", W'(dut.u_arb.rr_ptr_reg), W'(0));
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("mf_no_rsp", W'(rsp_valid), W'(0));
    end
    req_valid = 4'b1010;
    #1 chk("mf_lowest", W'(req_ready), W'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk); #1;
    chk_rsp("mf_after", 1, wide_sum);
    $display("after reset: rsp_id=%0d", rsp_id);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
